// File: rtl/elc3_mem_ctrl.sv
// LC-3 style memory controller: request/ready handshake with configurable wait states,
// internal RAM plus memory-mapped switch and LED registers at xFE00-xFE06.
module elc3_mem_ctrl #(
  parameter int WAIT_STATES = 2,
  parameter int RAM_WORDS   = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] ADDR,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic        R,
  input  logic [15:0] SW,
  output logic [15:0] LEDR
);

  localparam int          AW    = $clog2(RAM_WORDS);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);
  localparam logic [15:0] SWSR  = 16'hFE00;
  localparam logic [15:0] SWDR  = 16'hFE02;
  localparam logic [15:0] LEDSR = 16'hFE04;
  localparam logic [15:0] LEDDR = 16'hFE06;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q, din_q;
  logic        rw_q;
  logic        r_q;
  logic [15:0] dout_q;
  logic        src_ram_q;
  logic [15:0] ram_rd_q;
  logic [15:0] ledr_q;
  logic [15:0] sync1_q, sync2_q;
  logic [15:0] swsnap_q;

  logic [15:0] ram_mem [RAM_WORDS];

  logic [15:0] rd_addr_d;
  logic        rd_rw_d;
  logic        enter_done_d;
  logic        rd_load_d;
  logic        rd_mmio_d;
  logic [15:0] mmio_rdata_d;
  logic        wr_commit_d;
  logic        ram_we_d;

  // A read may be launched straight from IDLE (zero wait states), so look at the live
  // inputs there and at the captured request everywhere else.
  always_comb begin
    rd_addr_d    = (state_q == IDLE) ? ADDR : addr_q;
    rd_rw_d      = (state_q == IDLE) ? R_W  : rw_q;
    enter_done_d = ((state_q == IDLE) && MIO_EN && (WS == 4'd0)) ||
                   ((state_q == BUSY) && MIO_EN && (cnt_q == 4'd1));
    rd_load_d    = enter_done_d && !rd_rw_d;
    rd_mmio_d    = (rd_addr_d == SWSR) || (rd_addr_d == SWDR) ||
                   (rd_addr_d == LEDSR) || (rd_addr_d == LEDDR);
    mmio_rdata_d = 16'h0000;
    case (rd_addr_d)
      SWSR:    mmio_rdata_d = {(sync2_q != swsnap_q), 15'd0};
      SWDR:    mmio_rdata_d = sync2_q;
      LEDSR:   mmio_rdata_d = 16'h8000;
      LEDDR:   mmio_rdata_d = ledr_q;
      default: mmio_rdata_d = 16'h0000;
    endcase
    wr_commit_d  = (state_q == DONE) && rw_q;
    ram_we_d     = wr_commit_d && (addr_q != SWSR) && (addr_q != SWDR) &&
                   (addr_q != LEDSR) && (addr_q != LEDDR);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      din_q     <= 16'h0000;
      rw_q      <= 1'b0;
      r_q       <= 1'b0;
      dout_q    <= 16'h0000;
      src_ram_q <= 1'b0;
      ledr_q    <= 16'h0000;
      sync1_q   <= 16'h0000;
      sync2_q   <= 16'h0000;
      swsnap_q  <= 16'h0000;
    end else begin
      sync1_q <= SW;
      sync2_q <= sync1_q;
      r_q     <= enter_done_d;

      if (rd_load_d) begin
        src_ram_q <= !rd_mmio_d;
        if (rd_mmio_d) begin
          dout_q <= mmio_rdata_d;
        end
        if (rd_addr_d == SWDR) begin
          swsnap_q <= sync2_q;
        end
      end

      if (wr_commit_d && (addr_q == LEDDR)) begin
        ledr_q <= din_q;
      end

      case (state_q)
        IDLE: begin
          if (MIO_EN) begin
            addr_q  <= ADDR;
            din_q   <= DIN;
            rw_q    <= R_W;
            cnt_q   <= WS;
            state_q <= (WS == 4'd0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (!MIO_EN) begin
            cnt_q   <= 4'd0;
            state_q <= IDLE;
          end else if (cnt_q == 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset-free RAM port with an enabled registered read so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (ram_we_d) begin
      ram_mem[addr_q[AW-1:0]] <= din_q;
    end
    if (rd_load_d && !rd_mmio_d) begin
      ram_rd_q <= ram_mem[rd_addr_d[AW-1:0]];
    end
  end

  assign DOUT = src_ram_q ? ram_rd_q : dout_q;
  assign R    = r_q;
  assign LEDR = ledr_q;

endmodule

// File: tb/tb_elc3_mem_ctrl.sv
// Directed self-checking bench for elc3_mem_ctrl with WAIT_STATES=2, RAM_WORDS=1024.
module tb_elc3_mem_ctrl;

  logic        Clk;
  logic        Reset;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] ADDR;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic        R;
  logic [15:0] SW;
  logic [15:0] LEDR;

  int checks = 0;
  int errors = 0;

  elc3_mem_ctrl #(.WAIT_STATES(2), .RAM_WORDS(1024)) dut (
    .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W), .ADDR(ADDR),
    .DIN(DIN), .DOUT(DOUT), .R(R), .SW(SW), .LEDR(LEDR)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One complete access. Inputs are scrambled right after capture so the in-flight
  // request must rely on its captured copy. lat = edges from capture edge to R (0 = timeout).
  task automatic access(input logic rw, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rdata, output logic [15:0] led_at_r);
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = rw; ADDR = a; DIN = d;
    lat = 0; rdata = 16'hxxxx; led_at_r = 16'hxxxx;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      if (i == 0) begin
        ADDR = ~a; DIN = ~d; R_W = ~rw;
      end
      if (R) begin
        lat = i + 1; rdata = DOUT; led_at_r = LEDR;
        break;
      end
    end
    MIO_EN = 1'b0;
    @(posedge Clk); #1;
    $display("access rw=%0b addr=%h din=%h -> lat=%0d dout=%h ledr=%h", rw, a, d, lat, rdata, LEDR);
  endtask

  task automatic test_reset;
    Reset = 1'b0; MIO_EN = 1'b0; R_W = 1'b0; ADDR = 16'h0; DIN = 16'h0; SW = 16'h0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL reset_r got=%b exp=0", R); end
    checks++; if (DOUT !== 16'h0000) begin errors++; $display("FAIL reset_dout got=%h exp=0000", DOUT); end
    checks++; if (LEDR !== 16'h0000) begin errors++; $display("FAIL reset_ledr got=%h exp=0000", LEDR); end
    @(negedge Clk); Reset = 1'b1;
    $display("reset released r=%b dout=%h ledr=%h", R, DOUT, LEDR);
  endtask

  task automatic test_ram;
    int lat; logic [15:0] rd, led;
    access(1'b1, 16'h3000, 16'h1234, lat, rd, led);
    checks++; if (lat != 3) begin errors++; $display("FAIL ram_wr_lat got=%0d exp=3", lat); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL ram_wr_dout_kept got=%h exp=0000", rd); end
    access(1'b0, 16'h3000, 16'h0000, lat, rd, led);
    checks++; if (lat != 3) begin errors++; $display("FAIL ram_rd_lat got=%0d exp=3", lat); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL ram_rd_data got=%h exp=1234", rd); end
    checks++; if (DOUT !== 16'h1234) begin errors++; $display("FAIL ram_dout_hold got=%h exp=1234", DOUT); end
  endtask

  task automatic test_led;
    int lat; logic [15:0] rd, led;
    access(1'b1, 16'hFE06, 16'hBEEF, lat, rd, led);
    checks++; if (led !== 16'h0000) begin errors++; $display("FAIL led_before_commit got=%h exp=0000", led); end
    checks++; if (LEDR !== 16'hBEEF) begin errors++; $display("FAIL led_write got=%h exp=beef", LEDR); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL led_wr_dout_kept got=%h exp=1234", rd); end
    access(1'b0, 16'hFE06, 16'h0000, lat, rd, led);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL leddr_read got=%h exp=beef", rd); end
    access(1'b0, 16'hFE04, 16'h0000, lat, rd, led);
    checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL ledsr_read got=%h exp=8000", rd); end
    access(1'b1, 16'hFE04, 16'h1111, lat, rd, led);
    checks++; if (lat != 3) begin errors++; $display("FAIL ledsr_wr_lat got=%0d exp=3", lat); end
    checks++; if (LEDR !== 16'hBEEF) begin errors++; $display("FAIL ledsr_wr_ignored got=%h exp=beef", LEDR); end
  endtask

  task automatic test_sw;
    int lat; logic [15:0] rd, led;
    @(negedge Clk); SW = 16'h00A5;
    repeat (3) @(posedge Clk);
    access(1'b0, 16'hFE00, 16'h0000, lat, rd, led);
    checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL swsr_changed got=%h exp=8000", rd); end
    access(1'b0, 16'hFE02, 16'h0000, lat, rd, led);
    checks++; if (rd !== 16'h00A5) begin errors++; $display("FAIL swdr_read got=%h exp=00a5", rd); end
    access(1'b0, 16'hFE00, 16'h0000, lat, rd, led);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL swsr_clear got=%h exp=0000", rd); end
    @(negedge Clk); SW = 16'h00A4;
    repeat (3) @(posedge Clk);
    access(1'b0, 16'hFE00, 16'h0000, lat, rd, led);
    checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL swsr_rechange got=%h exp=8000", rd); end
  endtask

  task automatic test_abort;
    int lat; int seen_r; logic [15:0] rd, led;
    seen_r = 0;
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = 1'b0; ADDR = 16'h3000; DIN = 16'h0;
    @(posedge Clk); #1;
    MIO_EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      if (R) seen_r++;
    end
    $display("abort r_pulses=%0d dout=%h", seen_r, DOUT);
    checks++; if (seen_r != 0) begin errors++; $display("FAIL abort_no_r got=%0d exp=0", seen_r); end
    checks++; if (DOUT !== 16'h8000) begin errors++; $display("FAIL abort_dout got=%h exp=8000", DOUT); end
    access(1'b0, 16'h3000, 16'h0000, lat, rd, led);
    checks++; if (lat != 3) begin errors++; $display("FAIL after_abort_lat got=%0d exp=3", lat); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL after_abort_data got=%h exp=1234", rd); end
  endtask

  task automatic test_reset_mid;
    int lat; int seen_r; logic [15:0] rd, led;
    seen_r = 0;
    access(1'b1, 16'h0010, 16'hAAAA, lat, rd, led);
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = 1'b1; ADDR = 16'h0010; DIN = 16'h5555;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL midreset_r got=%b exp=0", R); end
    checks++; if (LEDR !== 16'h0000) begin errors++; $display("FAIL midreset_ledr got=%h exp=0000", LEDR); end
    checks++; if (DOUT !== 16'h0000) begin errors++; $display("FAIL midreset_dout got=%h exp=0000", DOUT); end
    MIO_EN = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      if (R) seen_r++;
    end
    $display("mid-access reset r_pulses=%0d ledr=%h", seen_r, LEDR);
    checks++; if (seen_r != 0) begin errors++; $display("FAIL midreset_no_r got=%0d exp=0", seen_r); end
    access(1'b0, 16'h0010, 16'h0000, lat, rd, led);
    checks++; if (rd !== 16'hAAAA) begin errors++; $display("FAIL midreset_no_write got=%h exp=aaaa", rd); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] rd, led;
    logic [7:0] r_seen;
    logic [7:0] r_exp;
    logic [15:0] d1, d2;
    r_exp = 8'b0100_0100;
    r_seen = 8'h00; d1 = 16'hxxxx; d2 = 16'hxxxx;
    access(1'b1, 16'h0001, 16'h1111, lat, rd, led);
    access(1'b1, 16'h0002, 16'h2222, lat, rd, led);
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = 1'b0; ADDR = 16'h0001; DIN = 16'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      r_seen[i] = R;
      if (i == 2) begin d1 = DOUT; ADDR = 16'h0002; end
      if (i == 6) begin d2 = DOUT; MIO_EN = 1'b0; end
    end
    $display("back-to-back r_pattern=%b d1=%h d2=%h", r_seen, d1, d2);
    checks++; if (r_seen !== r_exp) begin errors++; $display("FAIL b2b_r_pattern got=%b exp=%b", r_seen, r_exp); end
    checks++; if (d1 !== 16'h1111) begin errors++; $display("FAIL b2b_first got=%h exp=1111", d1); end
    checks++; if (d2 !== 16'h2222) begin errors++; $display("FAIL b2b_second got=%h exp=2222", d2); end
  endtask

  initial begin
    test_reset;
    test_ram;
    test_led;
    test_sw;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
